axil_two_port_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the AXI-lite slave port of the register wrapper (the s3_axi_* interface) between two local requesters.
- Each requester issues single-beat read or write commands on a simple valid/ready command port and receives a one-cycle response pulse.
- The block drives the AXI-lite master side and runs one transaction at a time. It never pipelines transactions and never has a second one outstanding.

---
 rtl/axil_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/axil_two_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axil_two_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI-lite two-port arbiter.
// Covers the FSM state encoding, the response codes and the default widths.
package axil_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrB,
    StRdA,
    StRdR,
    StRsp
  } state_e;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultAddrWidth = 8;
  localparam int unsigned DefaultRespWidth = 3;

  localparam int unsigned AxiRespOkay   = 0;
  localparam int unsigned AxiRespSlverr = 2;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant.
// The pointer moves to the non-granted requester whenever a grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    if (req[ptr_q]) begin
      grant[ptr_q] = 1'b1;
    end else if (req[~ptr_q]) begin
      grant[~ptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept && (|grant)) begin
      // After granting 0 the pointer favours 1, and the reverse.
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/axil_two_port_arbiter.sv
// Shares one AXI-lite master port between two single-beat requesters.
// Only one transaction is ever outstanding at a time.
module axil_two_port_arbiter
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned RESP_WIDTH = DefaultRespWidth
) (
  input  logic                      axi_aclk,
  input  logic                      axi_areset,
  input  logic [1:0]                req_valid,
  input  logic [1:0]                req_write,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  input  logic [2*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [1:0]                req_ready,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [RESP_WIDTH-1:0]     rsp_resp,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [RESP_WIDTH-1:0]     m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [RESP_WIDTH-1:0]     m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  state_e                  state_q;
  logic                    owner_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [StrbWidth-1:0]    wstrb_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic [1:0]              rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [RESP_WIDTH-1:0]   rsp_resp_q;

  logic [1:0] grant;
  logic       gsel;
  logic       accept;

  assign accept = (state_q == StIdle) && (|req_valid);
  assign gsel   = grant[1];

  rr_arb2 u_arb (
    .clk    (axi_aclk),
    .rst    (axi_areset),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Gated by reset so a requester holding valid through reset is never accepted.
  assign req_ready = (accept && !axi_areset) ? grant : 2'b00;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            owner_q <= gsel;
            addr_q  <= gsel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
            wdata_q <= gsel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
            wstrb_q <= gsel ? req_wstrb[2*StrbWidth-1:StrbWidth] : req_wstrb[StrbWidth-1:0];
            if (req_write[gsel]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWr;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRdA;
            end
          end
        end
        StWr: begin
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready) wvalid_q <= 1'b0;
          // Both channels finished in an earlier cycle.
          if (!awvalid_q && !wvalid_q) begin
            bready_q <= 1'b1;
            state_q  <= StWrB;
          end
        end
        StWrB: begin
          if (m_axi_bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= m_axi_bresp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= onehot2(owner_q);
            state_q     <= StRsp;
          end
        end
        StRdA: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdR;
          end
        end
        StRdR: begin
          if (m_axi_rvalid) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= m_axi_rresp;
            rsp_rdata_q <= m_axi_rdata;
            rsp_valid_q <= onehot2(owner_q);
            state_q     <= StRsp;
          end
        end
        StRsp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;

endmodule

// File: tb/tb_axil_two_port_arbiter.sv
// Directed bench for axil_two_port_arbiter with a small configurable AXI-lite slave.
module tb_axil_two_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [15:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_resp;
  logic [7:0]  m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [2:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;

  axil_two_port_arbiter dut (
    .axi_aclk      (clk),
    .axi_areset    (rst),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  int total = 0;
  int bad   = 0;

  // Slave configuration and observed beats.
  int          aw_delay = 0, w_delay = 0, r_delay = 0;
  logic [2:0]  bresp_cfg = '0, rresp_cfg = '0;
  logic [31:0] rdata_cfg = '0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [7:0]  aw_addr_seen = '0, ar_addr_seen = '0;
  logic [31:0] wdata_seen = '0;
  logic [3:0]  wstrb_seen = '0;

  // Handshakes are recorded from pre-edge values; ready/valid are redriven 1 after the edge.
  initial begin
    int  aw_w, w_w, r_w;
    bit  aw_done, w_done, b_pend, r_pend;
    aw_w = 0; w_w = 0; r_w = 0;
    aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0; r_w = 0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) begin
          aw_cnt++; aw_addr_seen = m_axi_awaddr; aw_done = 1;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          w_cnt++; wdata_seen = m_axi_wdata; wstrb_seen = m_axi_wstrb; w_done = 1;
        end
        if (m_axi_bvalid && m_axi_bready) begin b_cnt++; b_pend = 0; end
        if (aw_done && w_done) begin b_pend = 1; aw_done = 0; w_done = 0; end
        if (m_axi_arvalid && m_axi_arready) begin
          ar_cnt++; ar_addr_seen = m_axi_araddr; r_pend = 1; r_w = 0;
        end
        if (m_axi_rvalid && m_axi_rready) begin r_cnt++; r_pend = 0; end
      end
      #1;
      m_axi_awready = m_axi_awvalid && (aw_w >= aw_delay);
      if (m_axi_awvalid) aw_w++; else aw_w = 0;
      m_axi_wready = m_axi_wvalid && (w_w >= w_delay);
      if (m_axi_wvalid) w_w++; else w_w = 0;
      m_axi_bvalid  = b_pend;
      m_axi_bresp   = bresp_cfg;
      m_axi_arready = m_axi_arvalid;
      m_axi_rvalid  = r_pend && (r_w >= r_delay);
      if (r_pend) r_w++;
      m_axi_rdata   = rdata_cfg;
      m_axi_rresp   = rresp_cfg;
    end
  end

  task automatic set_req(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req_write[i]        = wr;
    req_addr[i*8 +: 8]  = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4] = s;
  endtask

  task automatic clear_counts();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
  endtask

  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin g = req_ready; break; end
    end
  endtask

  task automatic wait_rsp(output logic [1:0] v, output int lat);
    v = 2'b00; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) begin v = rsp_valid; lat = i; break; end
    end
  endtask

  task automatic test_reset();
    req_valid = 2'b01;
    set_req(0, 1'b1, 8'h3C, 32'h1234_5678, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      bad++; $display("FAIL reset_axi_valids: got %b want 00000",
                      {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
    end
    total++;
    if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb} !== 52'h0) begin
      bad++; $display("FAIL reset_payload: got %h want 0",
                      {m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb});
    end
    total++;
    if ({rsp_rdata, rsp_resp} !== 35'h0) begin
      bad++; $display("FAIL reset_rsp_data: got %h want 0", {rsp_rdata, rsp_resp});
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_write(input int who, input logic [7:0] a, input logic [31:0] d,
                           input logic [2:0] want_resp, input string tag);
    logic [1:0] g, v;
    int lat;
    clear_counts();
    set_req(who, 1'b1, a, d, 4'hF);
    req_valid = (who == 0) ? 2'b01 : 2'b10;
    wait_grant(g);
    total++; if (g !== ((who == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL %s_grant: got %b want %0d", tag, g, who); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(v, lat);
    total++; if (v !== ((who == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL %s_rsp_valid: got %b", tag, v); end
    total++; if (lat !== 4) begin bad++; $display("FAIL %s_latency: got %0d want 4", tag, lat); end
    total++; if (rsp_resp !== want_resp) begin bad++; $display("FAIL %s_resp: got %0d want %0d", tag, rsp_resp, want_resp); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL %s_rdata: got %h want 0", tag, rsp_rdata); end
    total++;
    if ({aw_addr_seen, wdata_seen, wstrb_seen} !== {a, d, 4'hF}) begin
      bad++; $display("FAIL %s_beats: got %h/%h/%h want %h/%h/f", tag, aw_addr_seen, wdata_seen, wstrb_seen, a, d);
    end
    total++; if (b_cnt !== 1) begin bad++; $display("FAIL %s_b_count: got %0d want 1", tag, b_cnt); end
    @(negedge clk);
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL %s_pulse_width: got %b want 00", tag, rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    run_write(0, 8'h00, 32'd25, 3'd0, "single_write");
  endtask

  task automatic test_split_write();
    logic [1:0] g;
    int aw_hi, w_hi, wbad, lat;
    aw_hi = 0; w_hi = 0; wbad = 0; lat = 0;
    clear_counts();
    aw_delay = 0; w_delay = 3;
    set_req(0, 1'b1, 8'h10, 32'd34, 4'hF);
    req_valid = 2'b01;
    wait_grant(g);
    total++; if (g !== 2'b01) begin bad++; $display("FAIL split_grant: got %b want 01", g); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid) begin
        w_hi++;
        if (m_axi_wdata !== 32'd34) wbad++;
      end
      if (rsp_valid !== 2'b00) begin lat = i; break; end
    end
    total++; if (aw_hi !== 1) begin bad++; $display("FAIL split_awvalid_cycles: got %0d want 1", aw_hi); end
    total++; if (w_hi !== 4) begin bad++; $display("FAIL split_wvalid_cycles: got %0d want 4", w_hi); end
    total++; if (wbad !== 0) begin bad++; $display("FAIL split_wdata_stable: got %0d bad cycles want 0", wbad); end
    total++; if (b_cnt !== 1) begin bad++; $display("FAIL split_b_count: got %0d want 1", b_cnt); end
    total++; if (lat !== 7) begin bad++; $display("FAIL split_latency: got %0d want 7", lat); end
    w_delay = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    logic [1:0] g, v;
    int lat;
    clear_counts();
    r_delay = 2; rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 3'd0;
    set_req(1, 1'b0, 8'h08, 32'h0, 4'h0);
    req_valid = 2'b10;
    wait_grant(g);
    total++; if (g !== 2'b10) begin bad++; $display("FAIL read_grant: got %b want 10", g); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(v, lat);
    total++; if (v !== 2'b10) begin bad++; $display("FAIL read_rsp_valid: got %b want 10", v); end
    total++; if (lat !== 5) begin bad++; $display("FAIL read_latency: got %0d want 5", lat); end
    total++; if (rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_rdata: got %h want deadbeef", rsp_rdata); end
    total++; if (rsp_resp !== 3'd0) begin bad++; $display("FAIL read_rresp: got %0d want 0", rsp_resp); end
    total++; if (ar_addr_seen !== 8'h08) begin bad++; $display("FAIL read_araddr: got %h want 08", ar_addr_seen); end
    total++; if (aw_cnt !== 0) begin bad++; $display("FAIL read_no_aw: got %0d want 0", aw_cnt); end
    r_delay = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] order [4];
    int at [4];
    int n, overlap;
    n = 0; overlap = 0;
    for (int i = 0; i < 4; i++) begin order[i] = 2'b00; at[i] = 0; end
    set_req(0, 1'b1, 8'h04, 32'h0000_0011, 4'hF);
    set_req(1, 1'b0, 8'h0C, 32'h0, 4'h0);
    req_valid = 2'b11;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((m_axi_awvalid || m_axi_wvalid || m_axi_bready) && (m_axi_arvalid || m_axi_rready)) overlap++;
      if (req_ready !== 2'b00) begin order[n] = req_ready; at[n] = c; n++; end
      if (n == 4) break;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_grant_count: got %0d want 4", n); end
    total++; if (order[0] !== 2'b01) begin bad++; $display("FAIL b2b_order0: got %b want 01", order[0]); end
    total++; if (order[1] !== 2'b10) begin bad++; $display("FAIL b2b_order1: got %b want 10", order[1]); end
    total++; if (order[2] !== 2'b01) begin bad++; $display("FAIL b2b_order2: got %b want 01", order[2]); end
    total++; if (order[3] !== 2'b10) begin bad++; $display("FAIL b2b_order3: got %b want 10", order[3]); end
    total++; if (at[1] - at[0] !== 5) begin bad++; $display("FAIL b2b_gap_write: got %0d want 5", at[1] - at[0]); end
    total++; if (at[2] - at[1] !== 4) begin bad++; $display("FAIL b2b_gap_read: got %0d want 4", at[2] - at[1]); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_error_resp();
    bresp_cfg = 3'd2;
    run_write(0, 8'h14, 32'd7, 3'd2, "err_write");
    bresp_cfg = 3'd0;
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] g, v;
    int lat, seen, pulses;
    seen = 0; pulses = 0;
    r_delay = 20;
    set_req(0, 1'b0, 8'h20, 32'h0, 4'h0);
    req_valid = 2'b01;
    wait_grant(g);
    total++; if (g !== 2'b01) begin bad++; $display("FAIL rst_pre_grant: got %b want 01", g); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_axi_rready === 1'b1) begin seen = 1; break; end
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL rst_reach_rd_r: got %0d want 1", seen); end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({m_axi_arvalid, m_axi_rready} !== 2'b00) begin
      bad++; $display("FAIL rst_abort_valids: got %b want 00", {m_axi_arvalid, m_axi_rready});
    end
    r_delay = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) pulses++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_no_rsp: got %0d pulses want 0", pulses); end
    @(posedge clk); #1;
    set_req(1, 1'b0, 8'h24, 32'h0, 4'h0);
    req_valid = 2'b11;
    wait_grant(g);
    total++; if (g !== 2'b01) begin bad++; $display("FAIL rst_pointer: got %b want 01", g); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(v, lat);
    total++; if (v !== 2'b01) begin bad++; $display("FAIL rst_post_rsp: got %b want 01", v); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_split_write();
    test_read();
    test_back_to_back();
    test_error_resp();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
